// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the decode-stage hazard controller.
//   FWD_* : 2-bit operand-mux select encodings (RF, EXE, MEM, WB).
//   slot_t: shadow copy of one in-flight destination tag {v, waddr, ld}.
package hazard_pkg;

  localparam int unsigned DEF_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic                  v;
    logic [DEF_ADDR_W-1:0] waddr;
    logic                  ld;
  } slot_t;

endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: compares one decode source address against the EXE, MEM
// and WB tag slots and picks the youngest matching producer.
//   src_use/src_addr : source read enable and register address
//   exe_slot         : full EXE slot (its ld bit drives the load-use flag)
//   mem_v/mem_waddr  : MEM slot tag
//   wb_v/wb_waddr    : WB slot tag
//   sel_c            : forwarding select (FWD_RF/EXE/MEM/WB), combinational
//   exe_ld_c         : source is produced by a load still in EXE, combinational
module hazard_src_match
  import hazard_pkg::*;
(
  input  logic                  src_use,
  input  logic [DEF_ADDR_W-1:0] src_addr,
  input  slot_t                 exe_slot,
  input  logic                  mem_v,
  input  logic [DEF_ADDR_W-1:0] mem_waddr,
  input  logic                  wb_v,
  input  logic [DEF_ADDR_W-1:0] wb_waddr,
  output logic [1:0]            sel_c,
  output logic                  exe_ld_c
);

  logic src_live;
  logic hit_exe;
  logic hit_mem;
  logic hit_wb;

  // r0 and unread sources never match anything
  assign src_live = src_use && (src_addr != '0);
  assign hit_exe  = src_live && exe_slot.v && (exe_slot.waddr == src_addr);
  assign hit_mem  = src_live && mem_v && (mem_waddr == src_addr);
  assign hit_wb   = src_live && wb_v && (wb_waddr == src_addr);

  // Youngest producer wins
  always_comb begin
    sel_c    = FWD_RF;
    exe_ld_c = 1'b0;
    if (hit_exe) begin
      sel_c    = FWD_EXE;
      exe_ld_c = exe_slot.ld;
    end else if (hit_mem) begin
      sel_c = FWD_MEM;
    end else if (hit_wb) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage operand hazard controller for the 5-stage LA32R
// pipeline. Shadows the destination tags in the EXE/MEM/WB slots, selects the
// forwarding source for both decode read ports and raises the decode stall.
// Optional build macro: HAZARD_PERF_EN (stall / load-use event counters).
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   ds_valid, ds_raddr1/2, ds_use1/2: decode instruction and its sources
//   ds_rf_we, ds_waddr, ds_is_load  : decode instruction's destination
//   es_allow_in                     : EXE can accept
//   es_to_ms_fire, ms_to_ws_fire    : pipeline hand-offs this cycle
//   ws_retire                       : WB writes back and leaves
//   stall, ds_fire                  : decode hold / decode issues (comb)
//   fwd_sel1, fwd_sel2              : operand-mux selects (comb)
//   stall_cycles, load_use_events   : perf counters (0 unless HAZARD_PERF_EN)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned WB_FWD = 1,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_valid,
  input  logic [ADDR_W-1:0] ds_raddr1,
  input  logic [ADDR_W-1:0] ds_raddr2,
  input  logic              ds_use1,
  input  logic              ds_use2,
  input  logic              ds_rf_we,
  input  logic [ADDR_W-1:0] ds_waddr,
  input  logic              ds_is_load,
  input  logic              es_allow_in,
  input  logic              es_to_ms_fire,
  input  logic              ms_to_ws_fire,
  input  logic              ws_retire,
  output logic              stall,
  output logic              ds_fire,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] load_use_events
);

  slot_t exe_q, exe_d;
  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;

  logic exe_ld1;
  logic exe_ld2;
  logic load_use_c;
  logic wb_block_c;
  logic unused_wb_ld;

  hazard_src_match u_match1 (
    .src_use   (ds_use1),
    .src_addr  (DEF_ADDR_W'(ds_raddr1)),
    .exe_slot  (exe_q),
    .mem_v     (mem_q.v),
    .mem_waddr (mem_q.waddr),
    .wb_v      (wb_q.v),
    .wb_waddr  (wb_q.waddr),
    .sel_c     (fwd_sel1),
    .exe_ld_c  (exe_ld1)
  );

  hazard_src_match u_match2 (
    .src_use   (ds_use2),
    .src_addr  (DEF_ADDR_W'(ds_raddr2)),
    .exe_slot  (exe_q),
    .mem_v     (mem_q.v),
    .mem_waddr (mem_q.waddr),
    .wb_v      (wb_q.v),
    .wb_waddr  (wb_q.waddr),
    .sel_c     (fwd_sel2),
    .exe_ld_c  (exe_ld2)
  );

  // WB-only matches block decode when the register file is not write-through
  assign load_use_c = ds_valid && (exe_ld1 || exe_ld2);
  assign wb_block_c = (WB_FWD == 0) && ((fwd_sel1 == FWD_WB) || (fwd_sel2 == FWD_WB));
  assign stall      = load_use_c || (ds_valid && wb_block_c);
  assign ds_fire    = ds_valid && !stall && es_allow_in;

  // The WB tag is never consumed as a load; its ld bit only rides along
  assign unused_wb_ld = wb_q.ld;

  // Slot shifts; every slot reads pre-edge values, so simultaneous shifts
  // neither drop nor duplicate a tag
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;

    if (ds_fire) begin
      exe_d.v     = ds_rf_we && (ds_waddr != '0);
      exe_d.waddr = DEF_ADDR_W'(ds_waddr);
      exe_d.ld    = ds_is_load;
    end else if (es_to_ms_fire) begin
      exe_d.v = 1'b0;
    end

    if (es_to_ms_fire) begin
      mem_d = exe_q;
    end else if (ms_to_ws_fire) begin
      mem_d.v = 1'b0;
    end

    if (ms_to_ws_fire) begin
      wb_d = mem_q;
    end else if (ws_retire) begin
      wb_d.v = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] lu_events_q, lu_events_d;
  logic              load_use_q, load_use_d;

  // Wrapping counters; load-use events count rising edges only
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    lu_events_d    = lu_events_q;
    load_use_d     = load_use_c;
    if (stall) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
    if (load_use_c && !load_use_q) begin
      lu_events_d = lu_events_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      lu_events_q    <= '0;
      load_use_q     <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      lu_events_q    <= lu_events_d;
      load_use_q     <= load_use_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign load_use_events = lu_events_q;
`else
  assign stall_cycles    = '0;
  assign load_use_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl. A second
// instance with WB_FWD=0 shares all inputs to exercise the WB-block stall.
module tb_hazard_ctrl;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PERF_W = 32;

  logic              clk;
  logic              reset;
  logic              ds_valid;
  logic [ADDR_W-1:0] ds_raddr1;
  logic [ADDR_W-1:0] ds_raddr2;
  logic              ds_use1;
  logic              ds_use2;
  logic              ds_rf_we;
  logic [ADDR_W-1:0] ds_waddr;
  logic              ds_is_load;
  logic              es_allow_in;
  logic              es_to_ms_fire;
  logic              ms_to_ws_fire;
  logic              ws_retire;

  logic              stall, ds_fire;
  logic [1:0]        fwd_sel1, fwd_sel2;
  logic [PERF_W-1:0] stall_cycles, load_use_events;

  logic              nf_stall, nf_ds_fire;
  logic [1:0]        nf_fwd_sel1, nf_fwd_sel2;
  logic [PERF_W-1:0] nf_stall_cycles, nf_load_use_events;

  int checks;
  int errors;

  hazard_ctrl #(.ADDR_W(ADDR_W), .WB_FWD(1), .PERF_W(PERF_W)) u_dut (
    .clk(clk), .reset(reset), .ds_valid(ds_valid),
    .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2),
    .ds_use1(ds_use1), .ds_use2(ds_use2),
    .ds_rf_we(ds_rf_we), .ds_waddr(ds_waddr), .ds_is_load(ds_is_load),
    .es_allow_in(es_allow_in), .es_to_ms_fire(es_to_ms_fire),
    .ms_to_ws_fire(ms_to_ws_fire), .ws_retire(ws_retire),
    .stall(stall), .ds_fire(ds_fire),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_cycles(stall_cycles), .load_use_events(load_use_events)
  );

  hazard_ctrl #(.ADDR_W(ADDR_W), .WB_FWD(0), .PERF_W(PERF_W)) u_dut_nf (
    .clk(clk), .reset(reset), .ds_valid(ds_valid),
    .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2),
    .ds_use1(ds_use1), .ds_use2(ds_use2),
    .ds_rf_we(ds_rf_we), .ds_waddr(ds_waddr), .ds_is_load(ds_is_load),
    .es_allow_in(es_allow_in), .es_to_ms_fire(es_to_ms_fire),
    .ms_to_ws_fire(ms_to_ws_fire), .ws_retire(ws_retire),
    .stall(nf_stall), .ds_fire(nf_ds_fire),
    .fwd_sel1(nf_fwd_sel1), .fwd_sel2(nf_fwd_sel2),
    .stall_cycles(nf_stall_cycles), .load_use_events(nf_load_use_events)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ds(input logic v, input logic [ADDR_W-1:0] r1, input logic u1,
                        input logic [ADDR_W-1:0] r2, input logic u2,
                        input logic we, input logic [ADDR_W-1:0] wa, input logic ld);
    ds_valid   = v;
    ds_raddr1  = r1;
    ds_use1    = u1;
    ds_raddr2  = r2;
    ds_use2    = u2;
    ds_rf_we   = we;
    ds_waddr   = wa;
    ds_is_load = ld;
  endtask

  task automatic idle();
    set_ds(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    es_allow_in   = 1'b1;
    es_to_ms_fire = 1'b0;
    ms_to_ws_fire = 1'b0;
    ws_retire     = 1'b0;
  endtask

  // Empty all three slots without issuing anything new
  task automatic drain();
    ds_valid      = 1'b0;
    es_to_ms_fire = 1'b1;
    ms_to_ws_fire = 1'b1;
    ws_retire     = 1'b1;
    repeat (3) cyc();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    cyc();
    set_ds(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
    checks++; if (fwd_sel1 !== 2'd0) begin errors++; $display("FAIL reset_fwd1 got %0d exp 0", fwd_sel1); end
    checks++; if (fwd_sel2 !== 2'd0) begin errors++; $display("FAIL reset_fwd2 got %0d exp 0", fwd_sel2); end
    cyc();
    reset = 1'b0;
    idle();
    cyc();
  endtask

  task automatic test_load_use();
    set_ds(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);
    #2;
    checks++; if (ds_fire !== 1'b1) begin errors++; $display("FAIL lu_issue_fire got %0b exp 1", ds_fire); end
    cyc();
    set_ds(1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0);
    es_to_ms_fire = 1'b1;
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", stall); end
    checks++; if (ds_fire !== 1'b0) begin errors++; $display("FAIL lu_fire got %0b exp 0", ds_fire); end
    checks++; if (fwd_sel1 !== 2'd1) begin errors++; $display("FAIL lu_fwd1_exe got %0d exp 1", fwd_sel1); end
    checks++; if (nf_stall !== 1'b1) begin errors++; $display("FAIL lu_nf_stall got %0b exp 1", nf_stall); end
    cyc();
    es_to_ms_fire = 1'b0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0b exp 0", stall); end
    checks++; if (fwd_sel1 !== 2'd2) begin errors++; $display("FAIL lu_fwd1_mem got %0d exp 2", fwd_sel1); end
    checks++; if (fwd_sel2 !== 2'd0) begin errors++; $display("FAIL lu_fwd2_rf got %0d exp 0", fwd_sel2); end
    checks++; if (ds_fire !== 1'b1) begin errors++; $display("FAIL lu_refire got %0b exp 1", ds_fire); end
    cyc();
    drain();
  endtask

  task automatic test_alu_chain();
    set_ds(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    cyc();
    set_ds(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    es_to_ms_fire = 1'b1;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b exp 0", stall); end
    checks++; if (fwd_sel2 !== 2'd1) begin errors++; $display("FAIL alu_fwd2_exe got %0d exp 1", fwd_sel2); end
    checks++; if (ds_fire !== 1'b1) begin errors++; $display("FAIL alu_fire got %0b exp 1", ds_fire); end
    cyc();
    es_to_ms_fire = 1'b0;
    ms_to_ws_fire = 1'b1;
    #2;
    checks++; if (fwd_sel2 !== 2'd2) begin errors++; $display("FAIL alu_fwd2_mem got %0d exp 2", fwd_sel2); end
    checks++; if (nf_stall !== 1'b0) begin errors++; $display("FAIL alu_nf_mem_stall got %0b exp 0", nf_stall); end
    cyc();
    ms_to_ws_fire = 1'b0;
    #2;
    checks++; if (fwd_sel2 !== 2'd3) begin errors++; $display("FAIL alu_fwd2_wb got %0d exp 3", fwd_sel2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_wb_stall got %0b exp 0", stall); end
    checks++; if (nf_stall !== 1'b1) begin errors++; $display("FAIL alu_nf_wb_block got %0b exp 1", nf_stall); end
    checks++; if (nf_ds_fire !== 1'b0) begin errors++; $display("FAIL alu_nf_fire got %0b exp 0", nf_ds_fire); end
    cyc();
    drain();
  endtask

  task automatic test_priority();
    set_ds(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    cyc();
    set_ds(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    es_to_ms_fire = 1'b1;
    cyc();
    set_ds(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    ms_to_ws_fire = 1'b1;
    cyc();
    // EXE=r3 (ALU), MEM empty, WB=r3
    set_ds(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    ms_to_ws_fire = 1'b0;
    #2;
    checks++; if (fwd_sel1 !== 2'd1) begin errors++; $display("FAIL prio_fwd1 got %0d exp 1", fwd_sel1); end
    checks++; if (fwd_sel2 !== 2'd1) begin errors++; $display("FAIL prio_fwd2 got %0d exp 1", fwd_sel2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall got %0b exp 0", stall); end
    checks++; if (nf_stall !== 1'b0) begin errors++; $display("FAIL prio_nf_stall got %0b exp 0", nf_stall); end
    cyc();
    // MEM=r3, WB=r3: MEM is younger
    es_to_ms_fire = 1'b0;
    #2;
    checks++; if (fwd_sel1 !== 2'd2) begin errors++; $display("FAIL prio_mem_over_wb got %0d exp 2", fwd_sel1); end
    cyc();
    drain();
  endtask

  task automatic test_r0_unused();
    set_ds(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);
    cyc();
    set_ds(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1);
    es_to_ms_fire = 1'b1;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %0b exp 0", stall); end
    checks++; if (fwd_sel1 !== 2'd0) begin errors++; $display("FAIL r0_fwd1 got %0d exp 0", fwd_sel1); end
    checks++; if (ds_fire !== 1'b1) begin errors++; $display("FAIL r0_fire got %0b exp 1", ds_fire); end
    cyc();
    // EXE holds a load to r9; r9 on port 2 but use2=0
    set_ds(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0);
    es_to_ms_fire = 1'b0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_stall got %0b exp 0", stall); end
    checks++; if (fwd_sel2 !== 2'd0) begin errors++; $display("FAIL unused_fwd2 got %0d exp 0", fwd_sel2); end
    ds_use2 = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL used_r9_stall got %0b exp 1", stall); end
    checks++; if (fwd_sel2 !== 2'd1) begin errors++; $display("FAIL used_r9_fwd2 got %0d exp 1", fwd_sel2); end
    cyc();
    drain();
  endtask

  task automatic test_backpressure();
    set_ds(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);
    cyc();
    set_ds(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bp_stall_%0d got %0b exp 1", i, stall); end
      checks++; if (ds_fire !== 1'b0) begin errors++; $display("FAIL bp_fire_%0d got %0b exp 0", i, ds_fire); end
      cyc();
    end
    es_to_ms_fire = 1'b1;
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bp_release_cycle got %0b exp 1", stall); end
    cyc();
    es_to_ms_fire = 1'b0;
    es_allow_in   = 1'b0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bp_after got %0b exp 0", stall); end
    checks++; if (fwd_sel2 !== 2'd2) begin errors++; $display("FAIL bp_fwd2_mem got %0d exp 2", fwd_sel2); end
    checks++; if (ds_fire !== 1'b0) begin errors++; $display("FAIL bp_no_allow got %0b exp 0", ds_fire); end
    es_allow_in = 1'b1;
    #1;
    checks++; if (ds_fire !== 1'b1) begin errors++; $display("FAIL bp_allow got %0b exp 1", ds_fire); end
    cyc();
    drain();
  endtask

  task automatic test_async_reset();
    set_ds(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);
    cyc();
    set_ds(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ar_pre got %0b exp 1", stall); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_immediate got %0b exp 0", stall); end
    checks++; if (fwd_sel1 !== 2'd0) begin errors++; $display("FAIL ar_fwd1 got %0d exp 0", fwd_sel1); end
    cyc();
    reset = 1'b0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_after got %0b exp 0", stall); end
    checks++; if (fwd_sel1 !== 2'd0) begin errors++; $display("FAIL ar_slots_empty got %0d exp 0", fwd_sel1); end
    cyc();
    idle();
  endtask

  task automatic test_perf();
    logic [PERF_W-1:0] exp_cnt;
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
    cyc();
    test_load_use();
    test_load_use();
`ifdef HAZARD_PERF_EN
    exp_cnt = PERF_W'(2);
`else
    exp_cnt = '0;
`endif
    checks++; if (stall_cycles !== exp_cnt) begin errors++; $display("FAIL perf_stall_cycles got %0d exp %0d", stall_cycles, exp_cnt); end
    checks++; if (load_use_events !== exp_cnt) begin errors++; $display("FAIL perf_lu_events got %0d exp %0d", load_use_events, exp_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_alu_chain();
    test_priority();
    test_r0_unused();
    test_backpressure();
    test_async_reset();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
